// File: rtl/axis_sideband_pkg.sv
// Shared types and helpers for sc16 sideband datapaths hung off axis_shift_register.
// The rounding/saturation helper is reused by every stage that narrows back to sc16.
package axis_sideband_pkg;

   typedef struct packed {
      logic signed [15:0] i;
      logic signed [15:0] q;
   } sc16_t;

   typedef struct packed {
      logic               sat;
      logic signed [15:0] val;
   } sat16_t;

   // (32767, 0): unity gain at SHIFT=15, so an unconfigured block is a near pass-through
   localparam logic [31:0] UNITY_COEFF = 32'h7FFF_0000;

   // Round half up, arithmetic shift, clip to the signed 16-bit range and flag the clip.
   // One guard bit above the 33-bit sum keeps the rounding add from wrapping.
   function automatic sat16_t sat_round_s16(input logic signed [32:0] v, input int shift);
      logic signed [33:0] rnd;
      logic signed [33:0] shr;
      sat16_t             res;
      rnd = {v[32], v} + (34'sd1 <<< (shift - 1));
      shr = rnd >>> shift;
      if (shr > 34'sd32767) begin
         res.sat = 1'b1;
         res.val = 16'sh7FFF;
      end else if (shr < -34'sd32768) begin
         res.sat = 1'b1;
         res.val = 16'sh8000;
      end else begin
         res.sat = 1'b0;
         res.val = shr[15:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/cmul_s16_stage.sv
// Product stage of the sc16 complex multiplier: four registered 16x16 signed products
// behind a common clock enable so each maps onto one DSP slice.
module cmul_s16_stage
   import axis_sideband_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  sc16_t              a,
   input  sc16_t              b,
   output logic signed [31:0] p_rr,
   output logic signed [31:0] p_ii,
   output logic signed [31:0] p_ri,
   output logic signed [31:0] p_ir
);

   logic signed [31:0] p_rr_q, p_rr_d;
   logic signed [31:0] p_ii_q, p_ii_d;
   logic signed [31:0] p_ri_q, p_ri_d;
   logic signed [31:0] p_ir_q, p_ir_d;

   always_comb begin
      p_rr_d = p_rr_q;
      p_ii_d = p_ii_q;
      p_ri_d = p_ri_q;
      p_ir_d = p_ir_q;
      if (en) begin
         p_rr_d = a.i * b.i;
         p_ii_d = a.q * b.q;
         p_ri_d = a.i * b.q;
         p_ir_d = a.q * b.i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_rr_q <= '0;
         p_ii_q <= '0;
         p_ri_q <= '0;
         p_ir_q <= '0;
      end else begin
         p_rr_q <= p_rr_d;
         p_ii_q <= p_ii_d;
         p_ri_q <= p_ri_d;
         p_ir_q <= p_ir_d;
      end
   end

   assign p_rr = p_rr_q;
   assign p_ii = p_ii_q;
   assign p_ri = p_ri_q;
   assign p_ir = p_ir_q;

endmodule

// File: rtl/axis_sideband_cmul.sv
// Three-stage sc16 complex multiplier driven purely by axis_shift_register stage strobes.
// Coefficients are double-buffered and swapped only on a sample boundary.
module axis_sideband_cmul
   import axis_sideband_pkg::*;
#(
   parameter int SHIFT = 15,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      stage_stb,
   input  logic [31:0]      in_data,
   input  logic [31:0]      coeff,
   input  logic             coeff_load,
   output logic [31:0]      out_data,
   output logic [CNT_W-1:0] sat_count,
   input  logic             sat_clear
);

   logic stb0, stb1, stb2;
   logic unused_stb;

   assign stb0       = stage_stb[0];
   assign stb1       = stage_stb[1];
   assign stb2       = stage_stb[2];
   assign unused_stb = ^stage_stb[15:3];

   logic [31:0]      pending_q, pending_d;
   logic [31:0]      active_q, active_d;
   logic             pend_flag_q, pend_flag_d;
   sc16_t            a_q, a_d;
   sc16_t            b_q, b_d;
   logic [31:0]      out_q, out_d;
   logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
   logic             xfer;

   // A pending coefficient is promoted on a sample strobe and used by that same sample
   assign xfer = stb0 & pend_flag_q;

   always_comb begin
      pending_d   = pending_q;
      active_d    = active_q;
      pend_flag_d = pend_flag_q;
      a_d         = a_q;
      b_d         = b_q;
      if (xfer) begin
         active_d    = pending_q;
         pend_flag_d = 1'b0;
      end
      // A load coinciding with a transfer is captured after the old value has moved over
      if (coeff_load) begin
         pending_d   = coeff;
         pend_flag_d = 1'b1;
      end
      if (stb0) begin
         a_d = sc16_t'(in_data);
         b_d = xfer ? sc16_t'(pending_q) : sc16_t'(active_q);
      end
   end

   logic signed [31:0] p_rr, p_ii, p_ri, p_ir;

   cmul_s16_stage u_prod (
      .clk   (clk),
      .reset (reset),
      .en    (stb1),
      .a     (a_q),
      .b     (b_q),
      .p_rr  (p_rr),
      .p_ii  (p_ii),
      .p_ri  (p_ri),
      .p_ir  (p_ir)
   );

   logic signed [32:0] sum_i, sum_q;
   sat16_t             res_i, res_q;

   assign sum_i = {p_rr[31], p_rr} - {p_ii[31], p_ii};
   assign sum_q = {p_ri[31], p_ri} + {p_ir[31], p_ir};
   assign res_i = sat_round_s16(sum_i, SHIFT);
   assign res_q = sat_round_s16(sum_q, SHIFT);

   always_comb begin
      out_d     = out_q;
      sat_cnt_d = sat_cnt_q;
      if (stb2) begin
         out_d = {res_i.val, res_q.val};
      end
      if (sat_clear) begin
         sat_cnt_d = '0;
      end else if (stb2 && (res_i.sat || res_q.sat) && (sat_cnt_q != '1)) begin
         sat_cnt_d = sat_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q   <= UNITY_COEFF;
         active_q    <= UNITY_COEFF;
         pend_flag_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         out_q       <= '0;
         sat_cnt_q   <= '0;
      end else begin
         pending_q   <= pending_d;
         active_q    <= active_d;
         pend_flag_q <= pend_flag_d;
         a_q         <= a_d;
         b_q         <= b_d;
         out_q       <= out_d;
         sat_cnt_q   <= sat_cnt_d;
      end
   end

   assign out_data  = out_q;
   assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_axis_sideband_cmul.sv
// Bench for axis_sideband_cmul: a small behavioural LATENCY=3 shift register drives the strobes,
// a scoreboard queue is filled at sample acceptance and drained by an output monitor.
module tb_axis_sideband_cmul;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] stage_stb;
   logic [31:0] in_data;
   logic [31:0] coeff;
   logic        coeff_load;
   logic [31:0] out_data;
   logic [15:0] sat_count;
   logic        sat_clear;

   always #5 clk = ~clk;

   axis_sideband_cmul #(.SHIFT(15), .CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .stage_stb  (stage_stb),
      .in_data    (in_data),
      .coeff      (coeff),
      .coeff_load (coeff_load),
      .out_data   (out_data),
      .sat_count  (sat_count),
      .sat_clear  (sat_clear)
   );

   // Flow-control model of the owning shift register
   logic       s_tvalid;
   logic       m_tready;
   logic [2:0] vld;
   logic       shift;

   assign shift     = !vld[2] || m_tready;
   assign stage_stb = {13'd0, shift & vld[1], shift & vld[0], shift & s_tvalid};

   always @(posedge clk or posedge reset) begin
      if (reset) vld <= '0;
      else if (shift) vld <= {vld[1:0], s_tvalid};
   end

   typedef struct {
      logic [31:0] data;
      logic [15:0] sat;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] m_pend, m_act;
   bit          m_flag;
   int          m_sat;
   bit          hand_en;
   logic [31:0] hand_val;
   int          stall_left;
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_out = 0;

   function automatic logic [32:0] ref_cmul(input logic [31:0] a, input logic [31:0] b);
      longint ar, ai, br, bi, vi, vq;
      bit     sat;
      ar  = longint'($signed(a[31:16]));
      ai  = longint'($signed(a[15:0]));
      br  = longint'($signed(b[31:16]));
      bi  = longint'($signed(b[15:0]));
      vi  = (ar * br - ai * bi + 64'sd16384) >>> 15;
      vq  = (ar * bi + ai * br + 64'sd16384) >>> 15;
      sat = 1'b0;
      if (vi > 32767) begin vi = 32767; sat = 1'b1; end
      else if (vi < -32768) begin vi = -32768; sat = 1'b1; end
      if (vq > 32767) begin vq = 32767; sat = 1'b1; end
      else if (vq < -32768) begin vq = -32768; sat = 1'b1; end
      return {sat, vi[15:0], vq[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock: evaluate the model for the coming edge, then step past it
   task automatic tick(output bit acc);
      logic [32:0] r;
      @(negedge clk);
      acc = stage_stb[0];
      if (sat_clear) m_sat = 0;
      if (stage_stb[0]) begin
         r = ref_cmul(in_data, m_flag ? m_pend : m_act);
         if (m_flag) begin
            m_act  = m_pend;
            m_flag = 1'b0;
         end
         if (r[32] && m_sat != 65535) m_sat++;
         sb_q.push_back('{data: (hand_en ? hand_val : r[31:0]), sat: 16'(m_sat)});
      end
      if (coeff_load) begin
         m_pend = coeff;
         m_flag = 1'b1;
      end
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
         m_tready = 1'b0;
         stall_left--;
      end else begin
         m_tready = 1'b1;
      end
   endtask

   task automatic send(input logic [31:0] d, input bit use_hand, input logic [31:0] hv);
      bit acc;
      int guard;
      acc      = 1'b0;
      guard    = 0;
      s_tvalid = 1'b1;
      in_data  = d;
      hand_en  = use_hand;
      hand_val = hv;
      while (!acc && guard < 50) begin
         tick(acc);
         guard++;
      end
      if (!acc) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: sample %h not accepted, required within 50 cycles", d);
      end
      s_tvalid = 1'b0;
      hand_en  = 1'b0;
   endtask

   task automatic load(input logic [31:0] c);
      bit acc;
      coeff      = c;
      coeff_load = 1'b1;
      tick(acc);
      coeff_load = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      int guard;
      guard = 0;
      while (sb_q.size() != 0 && guard < 200) begin
         tick(acc);
         guard++;
      end
      n_checks++;
      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain_timeout: %0d outputs pending, required 0", sb_q.size());
         sb_q.delete();
      end
      tick(acc);
      tick(acc);
   endtask

   // Output monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && vld[2] && m_tready) begin
            n_out++;
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_output: got %h, expected no output", out_data);
            end else begin
               e = sb_q.pop_front();
               $display("out %0d: data=%h sat_count=%0d (expected %h / %0d)",
                        n_out, out_data, sat_count, e.data, e.sat);
               check("out_data", out_data, e.data);
               check("sat_count", {16'd0, sat_count}, {16'd0, e.sat});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int n0;
      reset      = 1'b1;
      s_tvalid   = 1'b0;
      m_tready   = 1'b1;
      in_data    = '0;
      coeff      = '0;
      coeff_load = 1'b0;
      sat_clear  = 1'b0;
      stall_left = 0;
      hand_en    = 1'b0;
      hand_val   = '0;
      m_pend     = 32'h7FFF_0000;
      m_act      = 32'h7FFF_0000;
      m_flag     = 1'b0;
      m_sat      = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_data", out_data, 32'h0);
      check("reset_sat_count", {16'd0, sat_count}, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick(acc);

      // Default coefficient: near pass-through with half-up rounding
      send(32'h03E8_F830, 1'b1, 32'h03E8_F830);
      send(32'h8000_7FFF, 1'b1, 32'h8001_7FFE);
      drain();

      // (-32768,0) * (-32768,0) clips I
      load(32'h8000_0000);
      send(32'h8000_0000, 1'b1, 32'h7FFF_0000);
      drain();
      check("sat_count_after_clip", {16'd0, sat_count}, 32'd1);
      sat_clear = 1'b1;
      tick(acc);
      sat_clear = 1'b0;
      check("sat_count_after_clear", {16'd0, sat_count}, 32'd0);

      // 90 degree rotation at half scale
      load(32'h0000_4000);
      send(32'h2000_0000, 1'b1, 32'h0000_1000);
      drain();

      // Back to unity, then swap to rotation while samples 0..9 stream back to back;
      // the load coincides with sample 4's strobe, so 5..9 get the new coefficient
      load(32'h7FFF_0000);
      send(32'h0000_0000, 1'b1, 32'h0000_0000);
      drain();
      for (int k = 0; k < 10; k++) begin
         s_tvalid   = 1'b1;
         in_data    = {16'(200 * (k + 1)), 16'h0000};
         coeff      = 32'h0000_4000;
         coeff_load = (k == 4);
         hand_en    = 1'b1;
         hand_val   = (k <= 4) ? {16'(200 * (k + 1)), 16'h0000} : {16'h0000, 16'(100 * (k + 1))};
         tick(acc);
         coeff_load = 1'b0;
         n_checks++;
         if (!acc) begin
            n_errors++;
            $display("FAIL changeover_accept: sample %0d not accepted, required accepted", k);
         end
      end
      s_tvalid = 1'b0;
      hand_en  = 1'b0;
      drain();

      // 50 samples with random input gaps and a 4-cycle output stall
      load(32'h5A82_A57E);
      n0 = n_out;
      for (int k = 0; k < 50; k++) begin
         repeat ($urandom_range(0, 3)) tick(acc);
         if (k == 20) stall_left = 4;
         send($urandom(), 1'b0, 32'h0);
      end
      drain();
      check("stream_output_count", 32'(n_out - n0), 32'd50);
      sat_clear = 1'b1;
      tick(acc);
      sat_clear = 1'b0;
      check("sat_count_clear2", {16'd0, sat_count}, 32'd0);

      // Reset with samples in flight and a pending coefficient
      load(32'h8000_0000);
      send(32'h8000_0000, 1'b1, 32'h7FFF_0000);
      drain();
      load(32'h0000_4000);
      s_tvalid = 1'b1;
      in_data  = 32'h1234_5678;
      tick(acc);
      in_data  = 32'h4321_8765;
      tick(acc);
      s_tvalid = 1'b0;
      reset    = 1'b1;
      sb_q.delete();
      m_pend   = 32'h7FFF_0000;
      m_act    = 32'h7FFF_0000;
      m_flag   = 1'b0;
      m_sat    = 0;
      @(negedge clk);
      check("midreset_out_data", out_data, 32'h0);
      check("midreset_sat_count", {16'd0, sat_count}, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick(acc);
      send(32'h03E8_F830, 1'b1, 32'h03E8_F830);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/axis_sideband_cmul.md
# axis_sideband_cmul

Fixed-latency complex multiplier with rounding and saturation, built as the sideband datapath of an `axis_shift_register` instance configured with LATENCY=3 and SIDEBAND_DATAPATH=1. The shift register owns all AXI-Stream flow control (tvalid/tready/tlast). This block consumes its `stage_stb` and `m_sideband_data` and returns the product on `s_sideband_data`. It lets the team add sc16 gain/rotation stages to any stream without writing new handshake logic.

## Interface

Parameters:
- SHIFT, 15: right shift applied to full-precision sums before saturation; legal range 1..16.
- CNT_W, 16: width of the saturation event counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- stage_stb  in  16  per-stage enables from `axis_shift_register`; only bits [2:0] are used.
- in_data  in  32  sample from `m_sideband_data`; I in [31:16], Q in [15:0], signed sc16.
- coeff  in  32  coefficient, same packing as in_data.
- coeff_load  in  1  single-cycle strobe that captures `coeff` into the pending register.
- out_data  out  32  result to `s_sideband_data`, sc16.
- sat_count  out  CNT_W  number of samples with I or Q saturated; the count saturates at all-ones.
- sat_clear  in  1  synchronous clear of sat_count.

## Operation

- Pending/active coefficient:
  - `coeff_load` writes `pending`.
  - A `pend_flag` is set on load and cleared on transfer.
  - On a cycle with stage_stb[0]=1 and pend_flag=1, `pending` moves to `active`, and that same sample uses the new value.
  - If coeff_load and stage_stb[0] coincide, the transfer uses the old `pending`. The new value is captured and applies from the next sample.
- Stage 0 (enabled by stage_stb[0]): registers in_data and the active coefficient alongside it, giving per-sample coefficient alignment.
- Stage 1 (enabled by stage_stb[1]): four signed 16x16 products, each 32 bits: ar*br, ai*bi, ar*bi, ai*br.
- Stage 2 (enabled by stage_stb[2]):
  - I = ar*br − ai*bi and Q = ar*bi + ai*br, each 33-bit signed.
  - Add 2^(SHIFT−1) (round half up), then arithmetic shift right by SHIFT.
  - Saturate to [−32768, 32767].
  - Register the result into out_data.
  - Increment sat_count once per sample if either I or Q clipped.
- A stage with its strobe low holds its contents. This makes backpressure and input gaps transparent.
- sat_clear has priority over the increment in the same cycle.

## Timing

- Reset values: out_data=0, sat_count=0, all pipeline registers=0, pending=active=0x7FFF_0000, pend_flag=0.
  - Default gain is ≈1.0 at SHIFT=15.
- Latency is exactly three strobe events: a sample captured at stage_stb[0] appears on out_data the cycle after its stage_stb[2]. This matches the LATENCY=3 output stage.
- There are no cycle-count assumptions. Only strobes advance data.
- sat_count updates the cycle after the stage_stb[2] that clipped.
- Reset asserted mid-stream clears all state immediately. In-flight samples are lost, consistent with the shift register's own reset.

## Structure

- Shared package `axis_sideband_pkg`:
  - sc16 typedef with I/Q fields.
  - Constant for the unity coefficient.
  - Function `sat_round_s16(logic signed [32:0] v, int shift)`.
- One sub-module, `cmul_s16_stage`: the product stage (stage 1) with its clock enable, so it can map to DSP slices.
- The coefficient logic and stage 2 stay in the top level.

## Test plan

- After reset, with the default coefficient and input samples (1000,−2000) then (−32768,32767) passed through an `axis_shift_register` LATENCY=3 instance: output tdata is (1000,−2000) then (−32767,32766) (half-up rounding, unity scale 0x7FFF at SHIFT=15); sat_count=0.
- Coefficient (−32768,0) with input (−32768,0): output (32767,0); sat_count=1. Then sat_clear → 0.
- Coefficient (0,0x4000) with input (0x2000,0): output (0,0x1000), a 90° rotation at half scale.
- coeff_load of (0,0x4000) issued while samples 0..9 are in flight: samples entering before the next stage_stb[0] use the old coefficient; all later samples use the new one. Change-over is exactly at a sample boundary.
- 50 samples with random input gaps and a 4-cycle output tready=0 (same pattern as the shift-register gap test): all outputs match the reference model in order, with no duplicates or drops.
- Reset asserted for 2 cycles with 2 samples in flight: out_data=0 and sat_count=0 the cycle after reset assertion; the next sample after release is computed with the default coefficient.
